booth_div_16by8: RTL and testbench
==================================

Name: booth_div_16by8

Overview:
- Sequential signed fixed-point divider; the inverse operation of the team's 8x8->16 Booth/Dadda signed multiplier.
- Takes a 2*WIDTH-bit signed dividend (a product-width value) and a WIDTH-bit signed divisor.
- Returns a WIDTH-bit signed quotient and remainder using truncating (round-toward-zero) division.
- Radix-2 restoring iteration on magnitudes, with a valid/ready handshake on both the input and output sides.

Parameters:
- WIDTH, 8, divisor/quotient/remainder width; dividend is 2*WIDTH bits; iteration count is 2*WIDTH.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block idle, can accept
- dividend  input  2*WIDTH  signed dividend
- divisor  input  WIDTH  signed divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  signed quotient
- remainder  output  WIDTH  signed remainder; sign follows dividend
- ovf  output  1  quotient outside the signed WIDTH range, or divide by zero
- div_zero  output  1  divisor was zero

Behaviour:
- Reset (asynchronous, any state, including mid-calculation):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, quotient=0, remainder=0, ovf=0, div_zero=0.
  - Any in-flight operation is discarded.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch sign_q = dividend MSB XOR divisor MSB, and sign_r = dividend MSB.
  - Latch the magnitudes: |dividend| as unsigned 2*WIDTH bits (-32768 -> 32768) and |divisor| as unsigned WIDTH bits (-128 -> 128).
  - Clear the WIDTH+1-bit partial remainder, load the iteration counter with 2*WIDTH-1, go to CALC.
  - Operands are sampled only on this acceptance edge.
- CALC, one iteration per cycle:
  - Shift the partial remainder left, bringing in the dividend MSB.
  - Trial-subtract the divisor magnitude; if the result is non-negative, keep it and shift a 1 into the quotient, else restore and shift a 0.
  - When the counter reaches 0, go to FIX; otherwise decrement.
  - Exactly 2*WIDTH CALC cycles.
- FIX, one cycle; registers all outputs:
  - Apply signs: q = sign_q ? -mag_q : mag_q, r = sign_r ? -mag_r : mag_r.
  - ovf=1 if the signed q is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1], or if the divisor is 0.
  - quotient = low WIDTH bits of q (wraps on overflow).
  - Set out_valid=1, go to DONE.
- Divide by zero:
  - No early exit; the full latency still applies.
  - div_zero=1, ovf=1, quotient = all ones, remainder = dividend[WIDTH-1:0].
- Latency: out_valid is high starting 2*WIDTH+2 rising edges after the acceptance edge (18 for WIDTH=8).
- DONE:
  - out_valid and all result outputs are held stable until out_valid&&out_ready.
  - Then: out_valid=0, state IDLE, in_ready=1 on the following cycle.
  - in_ready=0 in CALC, FIX and DONE; there is no back-to-back acceptance.
- in_valid asserted while in_ready=0 is ignored; there is no queueing.
- Remainder invariant: |remainder| < |divisor|, and dividend = quotient*divisor + remainder whenever ovf=0.

Optional Feature:
- Macro: BOOTH_DIV_SAT_EN.
- When defined, on ovf the quotient saturates:
  - to 2^(WIDTH-1)-1 (127) if sign_q=0, otherwise to -2^(WIDTH-1) (-128);
  - on divide by zero, to 127 if the dividend is >= 0, else -128.
  - Remainder is unchanged from the non-saturating behaviour.
- When undefined: wrap behaviour as in FIX.
- Latency and handshake are identical either way.

Decomposition:
- Package booth_div_pkg:
  - state enum {IDLE, CALC, FIX, DONE};
  - default WIDTH constant;
  - functions/constants for the signed min/max of a WIDTH-bit value (saturation and overflow checks).
- Sub-module booth_div_step: combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: next partial remainder, quotient bit.
- FSM, counter and sign/fix logic stay in booth_div_16by8.

Test Plan:
- 100 / 7 -> quotient=14, remainder=2, ovf=0, div_zero=0; out_valid exactly 18 edges after acceptance.
- -100 / 7 -> q=-14, r=-2; 100 / -7 -> q=-14, r=2; -100 / -7 -> q=14, r=-2; all ovf=0.
- 16384 / -128 -> q=-128, r=0, ovf=0.
- -16384 / -128 -> ovf=1; q=0x80 without BOOTH_DIV_SAT_EN, q=127 with it.
- 1000 / 0 -> div_zero=1, ovf=1, r=0xE8.
  - Without BOOTH_DIV_SAT_EN: q=0xFF.
  - With BOOTH_DIV_SAT_EN: q=127.
  - -1000 / 0 with BOOTH_DIV_SAT_EN: q=-128.
- Back-pressure: out_ready held low for 5 cycles after out_valid.
  - Outputs stay stable and in_ready stays 0 throughout.
  - in_valid pulsed during DONE is ignored.
  - After the out_ready handshake, in_ready=1 on the next cycle.
- Reset after the 8th CALC cycle -> out_valid=0 and in_ready=1 immediately after reset deasserts; the next operation (-32768 / 255? use -32768 / -128 -> ovf=1) completes with correct flags.

Source files
------------

// File: rtl/booth_div_pkg.sv
// booth_div_pkg: shared types and constants for the sequential signed divider.
package booth_div_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } state_e;

    // Largest positive value of a w-bit signed number, as an unsigned magnitude
    function automatic int unsigned signed_max(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    // Magnitude of the most negative w-bit signed number
    function automatic int unsigned signed_min_mag(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/booth_div_step.sv
// booth_div_step: one combinational radix-2 restoring division iteration.
module booth_div_step
    import booth_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   i_prem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dmag,
    output logic [WIDTH:0]   o_prem,
    output logic             o_qbit
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH:0]   w_diff;

    // Shift in the next dividend bit, trial-subtract, restore on borrow
    always_comb begin
        w_shift = {i_prem, i_bit};
        w_diff  = w_shift[WIDTH:0] - {1'b0, i_dmag};
        // Top shift bit only sets with a zero divisor, where the result is overridden anyway
        o_qbit  = w_shift[WIDTH+1] | (w_shift[WIDTH:0] >= {1'b0, i_dmag});
        o_prem  = o_qbit ? w_diff : w_shift[WIDTH:0];
    end

endmodule

// File: rtl/booth_div_16by8.sv
// booth_div_16by8: sequential signed divider, 2*WIDTH-bit dividend by WIDTH-bit divisor,
// truncating toward zero, with valid/ready handshakes on both sides.
// Macro BOOTH_DIV_SAT_EN: saturate the quotient on overflow or divide by zero.
module booth_div_16by8
    import booth_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               ovf,
    output logic               div_zero
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(DW);
    localparam logic [DW-1:0]    PosMax  = DW'(signed_max(WIDTH));
    localparam logic [DW-1:0]    NegMag  = DW'(signed_min_mag(WIDTH));
    localparam logic [WIDTH-1:0] QSatPos = WIDTH'(signed_max(WIDTH));
    localparam logic [WIDTH-1:0] QSatNeg = WIDTH'(signed_min_mag(WIDTH));

    state_e           r_state;
    logic [DW-1:0]    r_dvd;     // dividend magnitude, becomes quotient magnitude
    logic [WIDTH-1:0] r_dmag;
    logic [WIDTH:0]   r_prem;
    logic [CW-1:0]    r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic [WIDTH-1:0] r_dvd_lo;  // raw low dividend bits, returned as remainder on /0

    logic [DW-1:0]    w_dvd_mag;
    logic [WIDTH-1:0] w_dsr_mag;
    logic [WIDTH:0]   w_prem_nxt;
    logic             w_qbit;
    logic [WIDTH-1:0] w_q_wrap;
    logic [WIDTH-1:0] w_r_signed;
    logic             w_dz;
    logic             w_ovf;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic             w_unused;

    booth_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_prem (r_prem),
        .i_bit  (r_dvd[DW-1]),
        .i_dmag (r_dmag),
        .o_prem (w_prem_nxt),
        .o_qbit (w_qbit)
    );

    // Operand magnitudes and sign/overflow fix-up of the finished iteration
    always_comb begin
        w_dvd_mag  = dividend[DW-1] ? -dividend : dividend;
        w_dsr_mag  = divisor[WIDTH-1] ? -divisor : divisor;
        w_q_wrap   = r_sign_q ? -r_dvd[WIDTH-1:0] : r_dvd[WIDTH-1:0];
        w_r_signed = r_sign_r ? -r_prem[WIDTH-1:0] : r_prem[WIDTH-1:0];
        w_unused   = r_prem[WIDTH];
        w_dz       = (r_dmag == '0);
        w_ovf      = w_dz | (r_sign_q ? (r_dvd > NegMag) : (r_dvd > PosMax));
        w_q_fix    = w_q_wrap;
        w_r_fix    = w_r_signed;
        if (w_dz) begin
            w_r_fix = r_dvd_lo;
`ifdef BOOTH_DIV_SAT_EN
            w_q_fix = r_sign_r ? QSatNeg : QSatPos;
`else
            w_q_fix = '1;
`endif
        end else if (w_ovf) begin
`ifdef BOOTH_DIV_SAT_EN
            w_q_fix = r_sign_q ? QSatNeg : QSatPos;
`else
            w_q_fix = w_q_wrap;
`endif
        end
    end

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            div_zero  <= 1'b0;
            r_dvd     <= '0;
            r_dmag    <= '0;
            r_prem    <= '0;
            r_cnt     <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_dvd_lo  <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_sign_q <= dividend[DW-1] ^ divisor[WIDTH-1];
                        r_sign_r <= dividend[DW-1];
                        r_dvd    <= w_dvd_mag;
                        r_dmag   <= w_dsr_mag;
                        r_dvd_lo <= dividend[WIDTH-1:0];
                        r_prem   <= '0;
                        r_cnt    <= CW'(DW - 1);
                        in_ready <= 1'b0;
                        r_state  <= StCalc;
                    end
                end
                StCalc: begin
                    r_prem <= w_prem_nxt;
                    r_dvd  <= {r_dvd[DW-2:0], w_qbit};
                    if (r_cnt == '0) begin
                        r_state <= StFix;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                StFix: begin
                    quotient  <= w_q_fix;
                    remainder <= w_r_fix;
                    ovf       <= w_ovf;
                    div_zero  <= w_dz;
                    out_valid <= 1'b1;
                    r_state   <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_div_16by8.sv
// tb_booth_div_16by8: directed self-checking bench for booth_div_16by8.
// Honours BOOTH_DIV_SAT_EN for the expected saturated quotients.
module tb_booth_div_16by8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        ovf;
    logic        div_zero;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef BOOTH_DIV_SAT_EN
    localparam logic [7:0] QNeg16k    = 8'h7F;  // -16384 / -128
    localparam logic [7:0] QDz1000    = 8'h7F;
    localparam logic [7:0] QDzM1000   = 8'h80;
    localparam logic [7:0] QNeg32kOvf = 8'h7F;  // -32768 / -128
`else
    localparam logic [7:0] QNeg16k    = 8'h80;
    localparam logic [7:0] QDz1000    = 8'hFF;
    localparam logic [7:0] QDzM1000   = 8'hFF;
    localparam logic [7:0] QNeg32kOvf = 8'h00;
`endif

    booth_div_16by8 #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation and wait for out_valid. lat counts rising edges with the
    // acceptance edge as edge 1, so the expected first out_valid edge is 18.
    task automatic start_op(input logic [15:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_cmp++; if (quotient !== 8'h00) begin n_fail++; $display("FAIL rst_quotient got %h want 00", quotient); end
        n_cmp++; if (remainder !== 8'h00) begin n_fail++; $display("FAIL rst_remainder got %h want 00", remainder); end
        n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b want 0", ovf); end
        n_cmp++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL rst_div_zero got %b want 0", div_zero); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_signed();
        logic [15:0] va [7] = '{16'h0064, 16'hFF9C, 16'h0064, 16'hFF9C, 16'h4000, 16'hC000, 16'hC001};
        logic [7:0]  vb [7] = '{8'h07, 8'h07, 8'hF9, 8'hF9, 8'h80, 8'h80, 8'h80};
        logic [7:0]  vq [7] = '{8'h0E, 8'hF2, 8'hF2, 8'h0E, 8'h80, QNeg16k, 8'h7F};
        logic [7:0]  vr [7] = '{8'h02, 8'hFE, 8'h02, 8'hFE, 8'h00, 8'h00, 8'h81};
        logic        vo [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 7; i++) begin
            start_op(va[i], vb[i], lat);
            n_cmp++; if (lat !== 18) begin n_fail++; $display("FAIL sgn%0d_latency got %0d want 18", i, lat); end
            n_cmp++; if (quotient !== vq[i]) begin n_fail++; $display("FAIL sgn%0d_quotient got %h want %h", i, quotient, vq[i]); end
            n_cmp++; if (remainder !== vr[i]) begin n_fail++; $display("FAIL sgn%0d_remainder got %h want %h", i, remainder, vr[i]); end
            n_cmp++; if (ovf !== vo[i]) begin n_fail++; $display("FAIL sgn%0d_ovf got %b want %b", i, ovf, vo[i]); end
            n_cmp++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL sgn%0d_div_zero got %b want 0", i, div_zero); end
            finish_op();
        end
    endtask

    task automatic test_div_zero();
        logic [15:0] va [2] = '{16'h03E8, 16'hFC18};
        logic [7:0]  vq [2] = '{QDz1000, QDzM1000};
        logic [7:0]  vr [2] = '{8'hE8, 8'h18};
        int lat;
        for (int i = 0; i < 2; i++) begin
            start_op(va[i], 8'h00, lat);
            n_cmp++; if (lat !== 18) begin n_fail++; $display("FAIL dz%0d_latency got %0d want 18", i, lat); end
            n_cmp++; if (quotient !== vq[i]) begin n_fail++; $display("FAIL dz%0d_quotient got %h want %h", i, quotient, vq[i]); end
            n_cmp++; if (remainder !== vr[i]) begin n_fail++; $display("FAIL dz%0d_remainder got %h want %h", i, remainder, vr[i]); end
            n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL dz%0d_ovf got %b want 1", i, ovf); end
            n_cmp++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL dz%0d_div_zero got %b want 1", i, div_zero); end
            finish_op();
        end
    endtask

    task automatic test_back_pressure();
        int lat;
        start_op(16'h0064, 8'h07, lat);
        n_cmp++; if (lat !== 18) begin n_fail++; $display("FAIL bp_latency got %0d want 18", lat); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            dividend = 16'h1234;
            divisor  = 8'h03;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d_out_valid got %b want 1", i, out_valid); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp%0d_in_ready got %b want 0", i, in_ready); end
            n_cmp++; if (quotient !== 8'h0E) begin n_fail++; $display("FAIL bp%0d_quotient got %h want 0e", i, quotient); end
            n_cmp++; if (remainder !== 8'h02) begin n_fail++; $display("FAIL bp%0d_remainder got %h want 02", i, remainder); end
        end
        finish_op();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        // An accepted stray pulse would have left the block busy here
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle%0d_in_ready got %b want 1", i, in_ready); end
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        @(negedge clk);
        dividend = 16'hFF9C;
        divisor  = 8'h07;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL postrst_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL postrst_in_ready got %b want 1", in_ready); end
        start_op(16'h8000, 8'h80, lat);
        n_cmp++; if (lat !== 18) begin n_fail++; $display("FAIL postrst_latency got %0d want 18", lat); end
        n_cmp++; if (quotient !== QNeg32kOvf) begin n_fail++; $display("FAIL postrst_quotient got %h want %h", quotient, QNeg32kOvf); end
        n_cmp++; if (remainder !== 8'h00) begin n_fail++; $display("FAIL postrst_remainder got %h want 00", remainder); end
        n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL postrst_ovf got %b want 1", ovf); end
        n_cmp++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL postrst_div_zero got %b want 0", div_zero); end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_signed();
        test_div_zero();
        test_back_pressure();
        test_reset_mid_calc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
